// File: rtl/tdm_mux16_pkg.sv
// Shared constants and state encoding for the 16-channel TDM transmitter.
package tdm_mux16_pkg;

  localparam int NCH  = 16;
  localparam int SELW = 4;

  localparam logic [SELW-1:0] LAST_SEL = SELW'(NCH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_mux16_if.sv
// Frame request / parallel data in, serial line and slot status out.
interface tdm_mux16_if;
  import tdm_mux16_pkg::*;

  logic            start;
  logic [NCH-1:0]  din;
  logic            y;
  logic [SELW-1:0] sel;
  logic            frame;
  logic            busy;
  logic            done;

  modport master (output start, din, input y, sel, frame, busy, done);
  modport slave  (input start, din, output y, sel, frame, busy, done);
endinterface

// File: rtl/tdm_mux16_slot_prescaler.sv
// Modulo-DIV slot counter; tick while count==DIV-1, tick_nxt when the next count will be DIV-1.
// No backpressure: clr dominates en.
module slot_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic tick_nxt
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick     = (cnt_q == LAST);
  assign tick_nxt = (cnt_d == LAST);

endmodule

// File: rtl/tdm_mux16.sv
// 16:1 TDM transmitter: one start edge to first bit, DIV cycles per slot, 16*DIV cycles per frame.
// No backpressure: start is honoured only when idle or on the done cycle, otherwise dropped.
module tdm_mux16
  import tdm_mux16_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  tdm_mux16_if.slave  bus
);

  state_t          state_q, state_d;
  logic [NCH-1:0]  shadow_q, shadow_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            y_q, y_d;
  logic            frame_q, frame_d;
  logic            done_q, done_d;
  logic            tick, tick_nxt;
  logic            pre_clr, pre_en;

  assign pre_clr = (state_q == IDLE);
  assign pre_en  = (state_q == SEND);

  slot_prescaler #(.DIV(DIV)) u_pre (
    .clk      (clk),
    .rst      (rst),
    .clr      (pre_clr),
    .en       (pre_en),
    .tick     (tick),
    .tick_nxt (tick_nxt)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SEND;
          shadow_d = bus.din;
          sel_d    = '0;
        end
      end
      SEND: begin
        if (tick) begin
          if (sel_q == LAST_SEL) begin
            // End of frame: a start here chains the next frame with no gap.
            sel_d = '0;
            if (bus.start) shadow_d = bus.din;
            else           state_d  = IDLE;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
    endcase

    // Outputs are computed from the next state so they are registered yet aligned.
    y_d     = (state_d == SEND) ? shadow_d[sel_d] : 1'b0;
    frame_d = (state_d == SEND) && (sel_d == '0);
    done_d  = (state_d == SEND) && (sel_d == LAST_SEL) && tick_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      sel_q    <= '0;
      y_q      <= 1'b0;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      y_q      <= y_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.sel   = sel_q;
  assign bus.frame = frame_q;
  assign bus.busy  = (state_q == SEND);
  assign bus.done  = done_q;

endmodule
